// File: rtl/serial_tx_framer.sv
// ============================================================================
// Module   : serial_tx_framer
// Purpose  : Parallel-to-serial framer with LOAD/READY handshake, per-bit
//            strobe and end-of-frame pulse. Optional even-parity trailer bit
//            enabled by defining SERIAL_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module serial_tx_framer #(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         CP,
    input  logic         CLR,
    input  logic [N-1:0] DI,
    input  logic         LOAD,
    input  logic         EN,
    output logic         READY,
    output logic         BUSY,
    output logic         SO,
    output logic         SO_VALID,
    output logic         DONE
);

    localparam int            CW         = $clog2(N + 1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
`ifdef SERIAL_TX_PARITY_EN
        , ST_PAR = 2'd2
`endif
    } state_t;

    state_t        r_state,    w_state;
    logic [CW-1:0] r_cnt,      w_cnt;
    logic [N-1:0]  r_shadow,   w_shadow;
    logic          r_so,       w_so;
    logic          r_so_valid, w_so_valid;
    logic          r_done,     w_done;
    logic          r_ready,    w_ready;
    logic          r_busy,     w_busy;

    // Shadow word rearranged into transmit order so bit k is always index k.
    logic [N-1:0]  w_ord;
    logic [N-1:0]  w_shifted;
    logic          w_di_first;
    logic          w_next_bit;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_ord      = r_shadow;
            assign w_di_first = DI[0];
        end else begin : g_msb_first
            for (genvar i = 0; i < N; i++) begin : g_rev
                assign w_ord[i] = r_shadow[N-1-i];
            end
            assign w_di_first = DI[N-1];
        end
    endgenerate

    assign w_shifted  = w_ord >> r_cnt;
    assign w_next_bit = w_shifted[0];

    always_ff @(posedge CP) begin
        if (CLR) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_shadow   <= '0;
            r_so       <= 1'b0;
            r_so_valid <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_shadow   <= w_shadow;
            r_so       <= w_so;
            r_so_valid <= w_so_valid;
            r_done     <= w_done;
            r_ready    <= w_ready;
            r_busy     <= w_busy;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_shadow   = r_shadow;
        w_so       = r_so;
        w_so_valid = 1'b0;
        w_done     = 1'b0;
        w_ready    = r_ready;
        w_busy     = r_busy;
        case (r_state)
            ST_IDLE: begin
                // The accept edge already launches bit 0; EN is not needed here.
                if (LOAD && r_ready) begin
                    w_shadow   = DI;
                    w_so       = w_di_first;
                    w_so_valid = 1'b1;
                    w_ready    = 1'b0;
                    w_busy     = 1'b1;
                    w_cnt      = CW'(1);
                    w_state    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (EN) begin
                    if (r_cnt < C_CNT_LAST) begin
                        w_so       = w_next_bit;
                        w_so_valid = 1'b1;
                        w_cnt      = r_cnt + CW'(1);
                    end else begin
`ifdef SERIAL_TX_PARITY_EN
                        w_so       = ^r_shadow;
                        w_so_valid = 1'b1;
                        w_state    = ST_PAR;
`else
                        w_so       = 1'b0;
                        w_done     = 1'b1;
                        w_busy     = 1'b0;
                        w_ready    = 1'b1;
                        w_cnt      = '0;
                        w_state    = ST_IDLE;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PAR: begin
                if (EN) begin
                    w_so    = 1'b0;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_ready = 1'b1;
                    w_cnt   = '0;
                    w_state = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign READY    = r_ready;
    assign BUSY     = r_busy;
    assign SO       = r_so;
    assign SO_VALID = r_so_valid;
    assign DONE     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_serial_tx_framer.sv
// ============================================================================
// Module   : tb_serial_tx_framer
// Purpose  : Self-checking bench for serial_tx_framer (LSB-first, MSB-first
//            and N=1 instances) with a bit-level scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_serial_tx_framer;

`ifdef SERIAL_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = 8 + P;

    logic       CP;
    logic       CLR;
    logic [7:0] DI;
    logic       LOAD;
    logic       LOAD_ONE;
    logic       EN;

    logic READY_L, BUSY_L, SO_L, SO_VALID_L, DONE_L;
    logic READY_M, BUSY_M, SO_M, SO_VALID_M, DONE_M;
    logic READY_1, BUSY_1, SO_1, SO_VALID_1, DONE_1;

    int   n_checks;
    int   n_pass;
    logic q_l[$];
    logic q_m[$];
    logic q_1[$];

    serial_tx_framer #(.N(8), .LSB_FIRST(1'b1)) u_lsb (
        .CP(CP), .CLR(CLR), .DI(DI), .LOAD(LOAD), .EN(EN),
        .READY(READY_L), .BUSY(BUSY_L), .SO(SO_L), .SO_VALID(SO_VALID_L), .DONE(DONE_L)
    );

    serial_tx_framer #(.N(8), .LSB_FIRST(1'b0)) u_msb (
        .CP(CP), .CLR(CLR), .DI(DI), .LOAD(LOAD), .EN(EN),
        .READY(READY_M), .BUSY(BUSY_M), .SO(SO_M), .SO_VALID(SO_VALID_M), .DONE(DONE_M)
    );

    serial_tx_framer #(.N(1), .LSB_FIRST(1'b1)) u_one (
        .CP(CP), .CLR(CLR), .DI(DI[0:0]), .LOAD(LOAD_ONE), .EN(EN),
        .READY(READY_1), .BUSY(BUSY_1), .SO(SO_1), .SO_VALID(SO_VALID_1), .DONE(DONE_1)
    );

    initial begin
        CP = 1'b0;
        forever #5 CP = ~CP;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] data, input bit with_one);
        for (int k = 0; k < 8; k++) begin
            q_l.push_back(data[k]);
            q_m.push_back(data[7-k]);
        end
        if (P == 1) begin
            q_l.push_back(^data);
            q_m.push_back(^data);
        end
        if (with_one) begin
            q_1.push_back(data[0]);
            if (P == 1) q_1.push_back(data[0]);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_ready_l"}, READY_L, 1'b1);
        check_eq({tag, "_busy_l"}, BUSY_L, 1'b0);
        check_eq({tag, "_so_l"}, SO_L, 1'b0);
        check_eq({tag, "_valid_l"}, SO_VALID_L, 1'b0);
        check_eq({tag, "_done_l"}, DONE_L, 1'b0);
        check_eq({tag, "_ready_m"}, READY_M, 1'b1);
        check_eq({tag, "_busy_m"}, BUSY_M, 1'b0);
        check_eq({tag, "_valid_1"}, SO_VALID_1, 1'b0);
        check_eq({tag, "_busy_1"}, BUSY_1, 1'b0);
    endtask

    // Scoreboard: every strobed bit must match the next expected bit.
    always @(negedge CP) begin
        if (SO_VALID_L === 1'b1) begin
            if (q_l.size() == 0) check_eq("sb_extra_l", SO_VALID_L, 1'b0);
            else check_eq("so_l", SO_L, q_l.pop_front());
        end
        if (SO_VALID_M === 1'b1) begin
            if (q_m.size() == 0) check_eq("sb_extra_m", SO_VALID_M, 1'b0);
            else check_eq("so_m", SO_M, q_m.pop_front());
        end
        if (SO_VALID_1 === 1'b1) begin
            if (q_1.size() == 0) check_eq("sb_extra_1", SO_VALID_1, 1'b0);
            else check_eq("so_1", SO_1, q_1.pop_front());
        end
    end

    // Entered and left just after a falling edge.
    task automatic run_frame(input logic [7:0] data, input int stall_at,
                             input int stall_len, input bit change_di);
        int edges;
        int edges_one;
        int nbits;
        bit seen;
        push_frame(data, 1'b1);
        DI       = data;
        LOAD     = 1'b1;
        LOAD_ONE = 1'b1;
        EN       = 1'b1;
        @(posedge CP);
        #1;
        LOAD     = 1'b0;
        LOAD_ONE = 1'b0;
        if (change_di) DI = 8'hFF;
        edges     = 0;
        edges_one = -1;
        nbits     = 0;
        seen      = 1'b0;
        while (!seen && edges < 60) begin
            @(negedge CP);
            if (SO_VALID_L === 1'b1) nbits++;
            if (DONE_1 === 1'b1 && edges_one < 0) edges_one = edges;
            if (DONE_L === 1'b1) begin
                seen = 1'b1;
                check_eq("done_latency", edges, FRAME + stall_len);
                check_eq("done_msb", DONE_M, 1'b1);
            end else begin
                if (stall_len > 0 && nbits == stall_at + 1 && SO_VALID_L === 1'b1) begin
                    EN = 1'b0;
                    for (int s = 0; s < stall_len; s++) begin
                        @(posedge CP);
                        edges++;
                        @(negedge CP);
                        check_eq("stall_valid", SO_VALID_L, 1'b0);
                        check_eq("stall_so_l", SO_L, data[stall_at]);
                        check_eq("stall_so_m", SO_M, data[7-stall_at]);
                    end
                    EN = 1'b1;
                end
                @(posedge CP);
                edges++;
            end
        end
        if (!seen) check_eq("done_timeout", DONE_L, 1'b1);
        check_eq("n1_done_latency", edges_one, 1 + P);
        @(posedge CP);
        @(negedge CP);
        check_eq("done_pulse_end", DONE_L, 1'b0);
        check_eq("ready_after", READY_L, 1'b1);
        check_eq("busy_after", BUSY_L, 1'b0);
        check_eq("sb_drain_l", q_l.size(), 0);
        check_eq("sb_drain_m", q_m.size(), 0);
        check_eq("sb_drain_1", q_1.size(), 0);
    endtask

    initial begin
        bit any_done;
        n_checks = 0;
        n_pass   = 0;
        CLR      = 1'b1;
        LOAD     = 1'b1;
        LOAD_ONE = 1'b1;
        EN       = 1'b1;
        DI       = 8'hFF;

        // Reset with LOAD asserted: nothing may be accepted.
        repeat (2) begin
            @(posedge CP);
            @(negedge CP);
            check_idle("reset");
        end
        CLR      = 1'b0;
        LOAD     = 1'b0;
        LOAD_ONE = 1'b0;
        @(posedge CP);
        @(negedge CP);
        check_idle("post_reset");

        run_frame(8'hA5, -1, 0, 1'b0);
        run_frame(8'h3C, -1, 0, 1'b1);
        run_frame(8'hF0, 2, 3, 1'b0);

        // LOAD held high: second accept exactly one edge after DONE.
        push_frame(8'h01, 1'b0);
        push_frame(8'h80, 1'b0);
        DI   = 8'h01;
        LOAD = 1'b1;
        EN   = 1'b1;
        @(posedge CP);
        #1;
        DI = 8'h80;
        repeat (FRAME) @(posedge CP);
        @(negedge CP);
        check_eq("held_done", DONE_L, 1'b1);
        check_eq("held_busy_at_done", BUSY_L, 1'b0);
        @(posedge CP);
        @(negedge CP);
        check_eq("held_reaccept_busy", BUSY_L, 1'b1);
        check_eq("held_reaccept_ready", READY_L, 1'b0);
        check_eq("held_reaccept_valid", SO_VALID_M, 1'b1);
        LOAD = 1'b0;
        repeat (FRAME) @(posedge CP);
        @(negedge CP);
        check_eq("held_done2", DONE_L, 1'b1);
        @(posedge CP);
        @(negedge CP);
        check_eq("held_drain_l", q_l.size(), 0);
        check_eq("held_drain_m", q_m.size(), 0);

        // Abort mid-frame while bit 4 is on the line.
        push_frame(8'hC3, 1'b1);
        DI       = 8'hC3;
        LOAD     = 1'b1;
        LOAD_ONE = 1'b1;
        @(posedge CP);
        #1;
        LOAD     = 1'b0;
        LOAD_ONE = 1'b0;
        repeat (4) @(posedge CP);
        @(negedge CP);
        CLR = 1'b1;
        @(posedge CP);
        #1;
        q_l.delete();
        q_m.delete();
        q_1.delete();
        CLR = 1'b0;
        @(negedge CP);
        check_idle("clr_abort");
        any_done = 1'b0;
        repeat (12) begin
            @(negedge CP);
            if (DONE_L === 1'b1 || DONE_M === 1'b1) any_done = 1'b1;
        end
        check_eq("clr_no_done", any_done, 1'b0);

        run_frame(8'h07, -1, 0, 1'b0);
        run_frame(8'h03, -1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
